// File: rtl/sb_pkg.sv
// sb_pkg: sideband constants, opcodes, parity bit indices and receive FSM state type.
// Shared by the sideband transmit and receive sides; no ports.
package sb_pkg;
    localparam logic [63:0] SB_PATTERN_WORD  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [4:0]  SB_OP_MEM_WR32   = 5'b00001;
    localparam logic [4:0]  SB_OP_MEM_WR64   = 5'b00011;
    localparam logic [4:0]  SB_OP_MSG_DATA   = 5'b11011;
    localparam logic [4:0]  SB_OP_MSG_NODATA = 5'b10010;
    localparam int          SB_CP_BIT        = 62;
    localparam int          SB_DP_BIT        = 63;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DELIVER} sb_rx_state_e;

    function automatic logic sb_has_data(input logic [4:0] opcode);
        return opcode inside {SB_OP_MEM_WR32, SB_OP_MEM_WR64, SB_OP_MSG_DATA};
    endfunction
endpackage

// File: rtl/sb_rx_deser.sv
// sb_rx_deser: LSB-first serial-to-64-bit deserializer with a registered word_done pulse.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_ser_data/i_ser_valid serial bit
// and qualifier; o_word_done one-cycle pulse with o_word holding the completed word;
// o_busy high while a word is partially captured.
module sb_rx_deser (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ser_data,
    input  logic        i_ser_valid,
    output logic        o_word_done,
    output logic [63:0] o_word,
    output logic        o_busy
);
    logic [63:0] sr_q, sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    always_comb begin
        sr_d   = i_ser_valid ? {i_ser_data, sr_q[63:1]} : sr_q;
        cnt_d  = i_ser_valid ? cnt_q + 6'd1 : cnt_q;
        done_d = i_ser_valid && (cnt_q == 6'd63);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // The shift register still holds the full word during the done cycle, even if
    // the next word's first bit is being sampled at the following edge.
    assign o_word_done = done_q;
    assign o_word      = sr_q;
    assign o_busy      = |cnt_q;
endmodule

// File: rtl/sb_rx_fsm.sv
// sb_rx_fsm: sideband receive controller; pattern detection, header/data parsing, parity
// checks and valid/ack message hand-off.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_ser_data/i_ser_valid serial input;
// i_pattern_detect_en selects pattern compare vs packet parse; i_msg_ack consumer accept;
// o_pattern_detected, o_parity_err, o_overflow one-cycle pulses; o_msg_valid with
// o_header/o_data/o_has_data held message; o_busy receiver activity.
module sb_rx_fsm
    import sb_pkg::*;
#(
    parameter int unsigned PATTERN_WORDS = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ser_data,
    input  logic        i_ser_valid,
    input  logic        i_pattern_detect_en,
    input  logic        i_msg_ack,
    output logic        o_pattern_detected,
    output logic        o_msg_valid,
    output logic [63:0] o_header,
    output logic [63:0] o_data,
    output logic        o_has_data,
    output logic        o_parity_err,
    output logic        o_overflow,
    output logic        o_busy
);
    logic        word_done, deser_busy;
    logic [63:0] word;

    sb_rx_deser u_deser (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ser_data  (i_ser_data),
        .i_ser_valid (i_ser_valid),
        .o_word_done (word_done),
        .o_word      (word),
        .o_busy      (deser_busy)
    );

    sb_rx_state_e state_q, state_d;
    logic         wd_q, wd_d;
    logic [63:0]  w_q, w_d, hdr_q, hdr_d;
    logic [3:0]   pcnt_q, pcnt_d;
    logic         pat_q, pat_d, perr_q, perr_d, ovf_q, ovf_d;
    logic         valid_q, valid_d, has_data_q, has_data_d;
    logic [63:0]  header_q, header_d, data_q, data_d;

    always_comb begin
        // Input stage: the word is captured once more before the FSM acts on it.
        wd_d       = word_done;
        w_d        = word_done ? word : w_q;
        state_d    = state_q;
        hdr_d      = hdr_q;
        pcnt_d     = i_pattern_detect_en ? pcnt_q : 4'd0;
        pat_d      = 1'b0;
        perr_d     = 1'b0;
        ovf_d      = 1'b0;
        valid_d    = valid_q;
        header_d   = header_q;
        data_d     = data_q;
        has_data_d = has_data_q;
        case (state_q)
            ST_IDLE: if (wd_q) begin
                if (i_pattern_detect_en) begin
                    if (w_q == SB_PATTERN_WORD) begin
                        pat_d  = (pcnt_q == 4'(PATTERN_WORDS - 1));
                        pcnt_d = pat_d ? 4'd0 : pcnt_q + 4'd1;
                    end else begin
                        pcnt_d = 4'd0;
                    end
                end else begin
                    hdr_d = w_q;
                    if (w_q[SB_CP_BIT] != ^w_q[61:0]) begin
                        perr_d = 1'b1;
                    end else if (sb_has_data(w_q[4:0])) begin
                        state_d = ST_DATA;
                    end else if (w_q[SB_DP_BIT]) begin
                        perr_d = 1'b1;
                    end else begin
                        state_d    = ST_DELIVER;
                        valid_d    = 1'b1;
                        header_d   = w_q;
                        data_d     = '0;
                        has_data_d = 1'b0;
                    end
                end
            end
            ST_DATA: if (wd_q) begin
                if (hdr_q[SB_DP_BIT] != ^w_q) begin
                    perr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_DELIVER;
                    valid_d    = 1'b1;
                    header_d   = hdr_q;
                    data_d     = w_q;
                    has_data_d = 1'b1;
                end
            end
            ST_DELIVER: begin
                // Words completing while a message is held are dropped, even on the ack cycle.
                ovf_d = wd_q;
                if (i_msg_ack) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            wd_q       <= 1'b0;
            w_q        <= '0;
            hdr_q      <= '0;
            pcnt_q     <= '0;
            pat_q      <= 1'b0;
            perr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            header_q   <= '0;
            data_q     <= '0;
            has_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            w_q        <= w_d;
            hdr_q      <= hdr_d;
            pcnt_q     <= pcnt_d;
            pat_q      <= pat_d;
            perr_q     <= perr_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            header_q   <= header_d;
            data_q     <= data_d;
            has_data_q <= has_data_d;
        end
    end

    assign o_pattern_detected = pat_q;
    assign o_parity_err       = perr_q;
    assign o_overflow         = ovf_q;
    assign o_msg_valid        = valid_q;
    assign o_header           = header_q;
    assign o_data             = data_q;
    assign o_has_data         = has_data_q;
    assign o_busy             = (state_q != ST_IDLE) || deser_busy;
endmodule
